// File: rtl/fp_div.sv
// fp_div: sequential IEEE-754 binary64 divider, out = n1 / n2, round to
// nearest even, flush-to-zero (subnormal inputs read as zero, no subnormal
// results).
//
// A restoring radix-2 divider produces one quotient bit per cycle for 55
// cycles. One more cycle normalizes, rounds and applies the special cases.
// Every operation, special or not, takes the same 56 cycles from the start
// edge to the done edge.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  synchronous active-high reset; aborts any divide in flight
//   start  in   1  capture n1/n2 and begin; ignored while busy
//   n1     in  64  dividend
//   n2     in  64  divisor
//   busy   out  1  divide in progress
//   done   out  1  one-cycle completion pulse
//   out    out 64  quotient, registered, held until the next completion
//   flags  out  5  {invalid, divzero, overflow, underflow, inexact}; this
//                  port exists only when FP_DIV_FLAGS_EN is defined
//
// Build option: define FP_DIV_FLAGS_EN to add the flags port and its logic.
module fp_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] n1,
  input  logic [63:0] n2,
  output logic        busy,
  output logic        done,
  output logic [63:0] out
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  localparam logic [63:0] QNAN = 64'h7FF8000000000000;

  typedef enum logic {S_IDLE, S_DIV} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [63:0] n1_reg, n1_next;
  logic [63:0] n2_reg, n2_next;
  logic [53:0] rem_reg, rem_next;
  logic [54:0] q_reg, q_next;
  logic [63:0] out_reg, out_next;
  logic        done_reg, done_next;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  flags_reg, flags_next;
  logic [4:0]  res_flags;
`endif

  // Operand fields of the captured operands.
  logic        s1, s2, rs;
  logic [10:0] e1, e2;
  logic [51:0] f1, f2;
  logic        nan1, nan2, inf1, inf2, zero1, zero2;

  assign s1 = n1_reg[63];
  assign e1 = n1_reg[62:52];
  assign f1 = n1_reg[51:0];
  assign s2 = n2_reg[63];
  assign e2 = n2_reg[62:52];
  assign f2 = n2_reg[51:0];
  assign rs = s1 ^ s2;

  assign nan1  = (e1 == 11'h7FF) && (f1 != 52'd0);
  assign nan2  = (e2 == 11'h7FF) && (f2 != 52'd0);
  assign inf1  = (e1 == 11'h7FF) && (f1 == 52'd0);
  assign inf2  = (e2 == 11'h7FF) && (f2 == 52'd0);
  // Exponent zero covers both true zero and subnormals (read as zero).
  assign zero1 = (e1 == 11'd0);
  assign zero2 = (e2 == 11'd0);

  // One restoring step. The divisor mantissa always carries its hidden 1, so
  // the remainder stays below 2^53 before the shift even for zero operands
  // (whose datapath result is discarded by the special-case select anyway).
  logic [52:0] m2;
  logic        rem_ge;
  logic [53:0] rem_diff;
  logic [52:0] rem_sub;

  assign m2       = {1'b1, f2};
  assign rem_ge   = (rem_reg >= {1'b0, m2});
  assign rem_diff = rem_reg - {1'b0, m2};
  assign rem_sub  = rem_ge ? rem_diff[52:0] : rem_reg[52:0];

  // Normalize and round.
  logic [54:0]        q_norm;
  logic [52:0]        mant_kept;
  logic               guard, sticky, lsb, round_up;
  logic [53:0]        mant_rnd;
  logic [52:0]        mant_fin;
  logic signed [12:0] exp_pre, exp_fin;
  logic               ovf, unf;

  assign q_norm    = q_reg[54] ? q_reg : {q_reg[53:0], 1'b0};
  assign mant_kept = q_norm[54:2];
  assign guard     = q_norm[1];
  // A set q_norm[0] with a zero remainder would need 2^54 to divide the
  // divisor mantissa, so the remainder alone is a complete sticky source.
  assign sticky    = (rem_reg != 54'd0);
  assign lsb       = q_norm[2];
  assign round_up  = guard & (sticky | lsb);
  assign mant_rnd  = {1'b0, mant_kept} + {53'd0, round_up};
  assign mant_fin  = mant_rnd[53] ? mant_rnd[53:1] : mant_rnd[52:0];

  assign exp_pre = {2'b00, e1} - {2'b00, e2} + 13'd1023 - {12'd0, ~q_reg[54]};
  assign exp_fin = exp_pre + {12'd0, mant_rnd[53]};
  assign ovf     = (exp_fin >= 13'sd2047);
  assign unf     = (exp_fin <= 13'sd0);

  logic unused_bits;
  assign unused_bits = ^{mant_fin[52], q_norm[0], rem_diff[53]};

  // Special-case select in priority order, then overflow/underflow, then
  // the ordinary rounded quotient.
  logic [63:0] res;

  always_comb begin
    res = {rs, exp_fin[10:0], mant_fin[51:0]};
`ifdef FP_DIV_FLAGS_EN
    res_flags = {4'b0000, guard | sticky};
`endif
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
      res = QNAN;
`ifdef FP_DIV_FLAGS_EN
      res_flags = 5'b10000;
`endif
    end else if (inf1) begin
      res = {rs, 11'h7FF, 52'd0};
`ifdef FP_DIV_FLAGS_EN
      res_flags = 5'b00000;
`endif
    end else if (zero2) begin
      res = {rs, 11'h7FF, 52'd0};
`ifdef FP_DIV_FLAGS_EN
      res_flags = 5'b01000;
`endif
    end else if (inf2 || zero1) begin
      res = {rs, 63'd0};
`ifdef FP_DIV_FLAGS_EN
      res_flags = 5'b00000;
`endif
    end else if (ovf) begin
      res = {rs, 11'h7FF, 52'd0};
`ifdef FP_DIV_FLAGS_EN
      res_flags = 5'b00101;
`endif
    end else if (unf) begin
      res = {rs, 63'd0};
`ifdef FP_DIV_FLAGS_EN
      res_flags = 5'b00011;
`endif
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    n1_next    = n1_reg;
    n2_next    = n2_reg;
    rem_next   = rem_reg;
    q_next     = q_reg;
    out_next   = out_reg;
    done_next  = 1'b0;
`ifdef FP_DIV_FLAGS_EN
    flags_next = flags_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          n1_next    = n1;
          n2_next    = n2;
          rem_next   = {2'b01, n1[51:0]};
          q_next     = 55'd0;
          cnt_next   = 6'd0;
          state_next = S_DIV;
        end
      end
      S_DIV: begin
        if (cnt_reg == 6'd55) begin
          out_next   = res;
          done_next  = 1'b1;
`ifdef FP_DIV_FLAGS_EN
          flags_next = res_flags;
`endif
          state_next = S_IDLE;
        end else begin
          rem_next = {rem_sub, 1'b0};
          q_next   = {q_reg[53:0], rem_ge};
          cnt_next = cnt_reg + 6'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 6'd0;
      n1_reg    <= 64'd0;
      n2_reg    <= 64'd0;
      rem_reg   <= 54'd0;
      q_reg     <= 55'd0;
      out_reg   <= 64'd0;
      done_reg  <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
      flags_reg <= 5'd0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      n1_reg    <= n1_next;
      n2_reg    <= n2_next;
      rem_reg   <= rem_next;
      q_reg     <= q_next;
      out_reg   <= out_next;
      done_reg  <= done_next;
`ifdef FP_DIV_FLAGS_EN
      flags_reg <= flags_next;
`endif
    end
  end

  assign busy = (state_reg == S_DIV);
  assign done = done_reg;
  assign out  = out_reg;
`ifdef FP_DIV_FLAGS_EN
  assign flags = flags_reg;
`endif

endmodule

// File: tb/tb_fp_div.sv
// Directed testbench for fp_div: hand-computed quotients, latency, special
// cases, start-while-busy and reset-abort behaviour.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] n1, n2;
  logic        busy, done;
  logic [63:0] out;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  flags;
`endif

  int errors = 0;
  int checks = 0;

  fp_div dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .n1   (n1),
    .n2   (n2),
    .busy (busy),
    .done (done),
    .out  (out)
`ifdef FP_DIV_FLAGS_EN
    ,
    .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one divide and wait (bounded) for done, sampling on negedges.
  task automatic run_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_q, input logic [4:0] exp_f);
    int cyc;
    @(negedge clk);
    n1 = a; n2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n1 = 64'hDEADBEEFCAFEF00D;
    n2 = 64'h0123456789ABCDEF;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'd56);
    check({tag, " quotient"}, out, exp_q);
    check({tag, " busy at done"}, {63'd0, busy}, 64'd0);
`ifdef FP_DIV_FLAGS_EN
    check({tag, " flags"}, {59'd0, flags}, {59'd0, exp_f});
`else
    if (exp_f === 5'bxxxxx) $display("unexpected flag argument");
`endif
    $display("%s: %h / %h -> %h in %0d cycles", tag, a, b, out, cyc);
  endtask

  initial begin
    int cyc;
    int ndone;
    rst = 1'b1; start = 1'b0; n1 = 64'd0; n2 = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset out", out, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);

    run_div("3/2", 64'h4008000000000000, 64'h4000000000000000, 64'h3FF8000000000000, 5'b00000);
    @(negedge clk);
    check("done single pulse", {63'd0, done}, 64'd0);

    run_div("1.5/5", 64'h3FF8000000000000, 64'h4014000000000000, 64'h3FD3333333333333, 5'b00001);
    run_div("-2/3", 64'hC000000000000000, 64'h4008000000000000, 64'hBFE5555555555555, 5'b00001);
    run_div("5/2", 64'h4014000000000000, 64'h4000000000000000, 64'h4004000000000000, 5'b00000);
    run_div("-5/-5", 64'hC014000000000000, 64'hC014000000000000, 64'h3FF0000000000000, 5'b00000);
    run_div("10/0.1", 64'h4024000000000000, 64'h3FB999999999999A, 64'h4059000000000000, 5'b00001);
    run_div("1/10 round up", 64'h3FF0000000000000, 64'h4024000000000000, 64'h3FB999999999999A, 5'b00001);
    run_div("1/0", 64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 5'b01000);
    run_div("0/0", 64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 5'b10000);
    run_div("overflow", 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 64'h7FF0000000000000, 5'b00101);
    run_div("underflow", 64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, 5'b00011);
    run_div("inf/2", 64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 5'b00000);
    run_div("2/inf", 64'h4000000000000000, 64'hFFF0000000000000, 64'h8000000000000000, 5'b00000);
    run_div("nan/1", 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'b10000);
    run_div("inf/inf", 64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 5'b10000);
    run_div("-0/5", 64'h8000000000000000, 64'h4014000000000000, 64'h8000000000000000, 5'b00000);
    run_div("subnormal/1", 64'h0000000000000001, 64'h3FF0000000000000, 64'h0000000000000000, 5'b00000);
    run_div("1/subnormal", 64'h3FF0000000000000, 64'h800FFFFFFFFFFFFF, 64'hFFF0000000000000, 5'b01000);

    // start pulsed while busy must be ignored
    @(negedge clk);
    n1 = 64'h4008000000000000; n2 = 64'h4000000000000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    repeat (9) begin
      @(negedge clk);
      cyc++;
    end
    n1 = 64'h3FF0000000000000; n2 = 64'h0000000000000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc++;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("busy-start latency", 64'(cyc), 64'd56);
    check("busy-start quotient", out, 64'h3FF8000000000000);
    ndone = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("busy-start no extra done", 64'(ndone), 64'd0);
    $display("busy-start: result %h after %0d cycles, extra done %0d", out, cyc, ndone);

    // reset in the middle of a divide aborts it
    @(negedge clk);
    n1 = 64'h4014000000000000; n2 = 64'h4000000000000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort out", out, 64'd0);
    ndone = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", 64'(ndone), 64'd0);
    $display("reset abort: busy %0d out %h done pulses %0d", busy, out, ndone);

    run_div("after reset 1/3", 64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, 5'b00001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
